// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the SDRAM controller and the SDRAM responder.
// Holds the command encodings {CSn,RASn,CASn,WEn}, the positions of the mode
// register fields and of the auto/all flag in ADDR, and the CAS-latency and
// burst-length decode helpers.
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_LOAD_MODE    = 4'b0000,
        CMD_AUTO_REFRESH = 4'b0001,
        CMD_PRECHARGE    = 4'b0010,
        CMD_ACTIVE       = 4'b0011,
        CMD_WRITE        = 4'b0100,
        CMD_READ         = 4'b0101,
        CMD_BURST_STOP   = 4'b0110,
        CMD_NOP          = 4'b0111
    } sdram_cmd_e;

    localparam int ADDR_AUTO_BIT = 10;
    localparam int MODE_CL_LSB   = 4;
    localparam int MODE_CL_MSB   = 6;
    localparam int MODE_BL_LSB   = 0;
    localparam int MODE_BL_MSB   = 2;

    localparam logic [2:0] CL_CODE_2   = 3'd2;
    localparam logic [2:0] CL_CODE_3   = 3'd3;
    localparam logic [2:0] BL_CODE_MAX = 3'd3;

    // CSn high deselects the device, which behaves exactly like a NOP.
    function automatic sdram_cmd_e decode_cmd(input logic [3:0] bits);
        if (bits[3]) begin
            return CMD_NOP;
        end else begin
            return sdram_cmd_e'(bits);
        end
    endfunction

    function automatic logic cl_legal(input logic [2:0] code);
        return (code == CL_CODE_2) || (code == CL_CODE_3);
    endfunction

    function automatic logic bl_legal(input logic [2:0] code);
        return code <= BL_CODE_MAX;
    endfunction

    // Burst-length code 0..3 -> 1, 2, 4, 8 words.
    function automatic logic [3:0] bl_words(input logic [1:0] code);
        case (code)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            2'd3:    return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// sdram_resp_mem: 2^AW x 16 storage for the SDRAM responder.
// Ports: clk; we/be/waddr/wdata synchronous write with per-byte enables
// (be[1] = upper byte); re/raddr synchronous read, rdata holds the last word read.
// Contents and rdata have no reset so they survive a responder reset.
module sdram_resp_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;

    // Byte-masked write port.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem_q[waddr][7:0]  <= wdata[7:0];
            if (be[1]) mem_q[waddr][15:8] <= wdata[15:8];
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: behavioural SDRAM device model with a real memory behind it.
// Ports: HCLK, HRESETn (async, active-low); CKE, CSn/RASn/CASn/WEn command;
// ADDR (row/column/mode, ADDR[10] = auto/all), BA bank; DQ bidirectional data,
// DQM byte write mask; ERR sticky protocol error; REF_COUNT auto-refresh count.
// Optional feature: define SDRAM_RESP_CHECK_EN to build the protocol checker
// that drives ERR; without it ERR is constant 0.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_AW   = 12,
    parameter int ROW_BITS = 13,
    parameter int COL_BITS = 9
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        CKE,
    input  logic        CSn,
    input  logic        RASn,
    input  logic        CASn,
    input  logic        WEn,
    input  logic [12:0] ADDR,
    input  logic [1:0]  BA,
    inout  wire  [15:0] DQ,
    input  logic [1:0]  DQM,
    output logic        ERR,
    output logic [15:0] REF_COUNT
);

    sdram_cmd_e cmd_s;
    logic [3:0] open_q, open_d;
    logic [ROW_BITS-1:0] row_q [4];
    logic [ROW_BITS-1:0] row_d [4];
    logic cl3_q, cl3_d;
    logic [1:0] bl_code_q, bl_code_d;
    logic [15:0] ref_q, ref_d;

    // Burst engine state: next word index, start column and its bank/row.
    logic bst_act_q, bst_act_d, bst_wr_q, bst_wr_d;
    logic [1:0] bst_bank_q, bst_bank_d;
    logic [ROW_BITS-1:0] bst_row_q, bst_row_d;
    logic [COL_BITS-1:0] bst_col_q, bst_col_d;
    logic [3:0] bst_idx_q, bst_idx_d, bst_len_q, bst_len_d;

    logic stop_s, issue_s, iss_wr_s;
    logic [1:0] iss_bank_s;
    logic [ROW_BITS-1:0] iss_row_s;
    logic [COL_BITS-1:0] iss_col_s, col_mask_s, col_k_s;
    logic [3:0] iss_k_s, iss_len_s;
    logic [MEM_AW-1:0] mem_addr_s;
    logic [15:0] mem_rdata_s;

    // Read data pipeline: memory output tag, then two delay stages feeding DQ.
    logic rd_vld_q, rd_vld_d, p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
    logic [15:0] p1_dat_q, p1_dat_d, p2_dat_q, p2_dat_d;
    logic dq_oe_q, dq_oe_d;
    logic [15:0] dq_q, dq_d;

    assign cmd_s = CKE ? decode_cmd({CSn, RASn, CASn, WEn}) : CMD_NOP;

    // A burst stops on BURST_STOP or on a precharge that covers its bank.
    assign stop_s = (cmd_s == CMD_BURST_STOP) ||
                    ((cmd_s == CMD_PRECHARGE) && (ADDR[ADDR_AUTO_BIT] || (BA == bst_bank_q)));

    // Choose the word to access this edge: a new command restarts, else the burst continues.
    always_comb begin
        issue_s    = 1'b0;
        iss_wr_s   = bst_wr_q;
        iss_bank_s = bst_bank_q;
        iss_row_s  = bst_row_q;
        iss_col_s  = bst_col_q;
        iss_k_s    = bst_idx_q;
        iss_len_s  = bst_len_q;
        if ((cmd_s == CMD_READ) || (cmd_s == CMD_WRITE)) begin
            issue_s    = 1'b1;
            iss_wr_s   = (cmd_s == CMD_WRITE);
            iss_bank_s = BA;
            iss_row_s  = row_q[BA];
            iss_col_s  = ADDR[COL_BITS-1:0];
            iss_k_s    = 4'd0;
            iss_len_s  = bl_words(bl_code_q);
        end else if (CKE && bst_act_q && !stop_s) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Sequential wrap: the column advances only inside its BL-aligned block.
    assign col_mask_s = {{(COL_BITS-4){1'b0}}, iss_len_s - 4'd1};
    assign col_k_s    = (iss_col_s & ~col_mask_s) |
                        ((iss_col_s + {{(COL_BITS-4){1'b0}}, iss_k_s}) & col_mask_s);
    assign mem_addr_s = MEM_AW'({iss_bank_s, iss_row_s, col_k_s});

    sdram_resp_mem #(.AW(MEM_AW)) u_mem (
        .clk   (HCLK),
        .we    (issue_s && iss_wr_s),
        .be    (~DQM),
        .waddr (mem_addr_s),
        .wdata (DQ),
        .re    (issue_s && !iss_wr_s),
        .raddr (mem_addr_s),
        .rdata (mem_rdata_s)
    );

    // Burst engine next state.
    always_comb begin
        bst_act_d  = bst_act_q;
        bst_wr_d   = bst_wr_q;
        bst_bank_d = bst_bank_q;
        bst_row_d  = bst_row_q;
        bst_col_d  = bst_col_q;
        bst_idx_d  = bst_idx_q;
        bst_len_d  = bst_len_q;
        if (issue_s) begin
            bst_act_d  = (iss_k_s + 4'd1) != iss_len_s;
            bst_wr_d   = iss_wr_s;
            bst_bank_d = iss_bank_s;
            bst_row_d  = iss_row_s;
            bst_col_d  = iss_col_s;
            bst_idx_d  = iss_k_s + 4'd1;
            bst_len_d  = iss_len_s;
        end else if (stop_s) begin
            bst_act_d = 1'b0;
        end else begin
            bst_act_d = bst_act_q;
        end
    end

    // Read pipeline: a WRITE flushes it so the controller owns DQ; CKE low freezes it.
    always_comb begin
        rd_vld_d = rd_vld_q;
        p1_vld_d = p1_vld_q;
        p1_dat_d = p1_dat_q;
        p2_vld_d = p2_vld_q;
        p2_dat_d = p2_dat_q;
        dq_oe_d  = dq_oe_q;
        dq_d     = dq_q;
        if (CKE) begin
            if (cmd_s == CMD_WRITE) begin
                rd_vld_d = 1'b0;
                p1_vld_d = 1'b0;
                p2_vld_d = 1'b0;
                dq_oe_d  = 1'b0;
            end else begin
                rd_vld_d = issue_s && !iss_wr_s;
                p1_vld_d = rd_vld_q;
                p1_dat_d = mem_rdata_s;
                p2_vld_d = p1_vld_q;
                p2_dat_d = p1_dat_q;
                dq_oe_d  = cl3_q ? p2_vld_q : p1_vld_q;
                dq_d     = cl3_q ? p2_dat_q : p1_dat_q;
            end
        end else begin
            dq_oe_d = dq_oe_q;
        end
    end

    // Release DQ in the same cycle a WRITE is presented.
    assign DQ = (dq_oe_q && (cmd_s != CMD_WRITE)) ? dq_q : 16'hzzzz;

    // Bank table, mode register and refresh counter.
    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        cl3_d     = cl3_q;
        bl_code_d = bl_code_q;
        ref_d     = ref_q;
        case (cmd_s)
            CMD_ACTIVE: begin
                open_d[BA] = 1'b1;
                row_d[BA]  = ADDR[ROW_BITS-1:0];
            end
            CMD_PRECHARGE: begin
                if (ADDR[ADDR_AUTO_BIT]) open_d = 4'b0000;
                else                     open_d[BA] = 1'b0;
            end
            CMD_AUTO_REFRESH: ref_d = ref_q + 16'd1;
            CMD_LOAD_MODE: begin
                // Illegal field codes leave that field unchanged.
                if (cl_legal(ADDR[MODE_CL_MSB:MODE_CL_LSB])) cl3_d = ADDR[MODE_CL_LSB];
                else                                         cl3_d = cl3_q;
                if (bl_legal(ADDR[MODE_BL_MSB:MODE_BL_LSB])) bl_code_d = ADDR[MODE_BL_LSB+1:MODE_BL_LSB];
                else                                         bl_code_d = bl_code_q;
            end
            default: open_d = open_q;
        endcase
    end

    // State registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            open_q     <= 4'b0000;
            for (int i = 0; i < 4; i++) row_q[i] <= {ROW_BITS{1'b0}};
            cl3_q      <= 1'b0;
            bl_code_q  <= 2'd0;
            ref_q      <= 16'd0;
            bst_act_q  <= 1'b0;
            bst_wr_q   <= 1'b0;
            bst_bank_q <= 2'd0;
            bst_row_q  <= {ROW_BITS{1'b0}};
            bst_col_q  <= {COL_BITS{1'b0}};
            bst_idx_q  <= 4'd0;
            bst_len_q  <= 4'd1;
            rd_vld_q   <= 1'b0;
            p1_vld_q   <= 1'b0;
            p1_dat_q   <= 16'd0;
            p2_vld_q   <= 1'b0;
            p2_dat_q   <= 16'd0;
            dq_oe_q    <= 1'b0;
            dq_q       <= 16'd0;
        end else begin
            open_q     <= open_d;
            row_q      <= row_d;
            cl3_q      <= cl3_d;
            bl_code_q  <= bl_code_d;
            ref_q      <= ref_d;
            bst_act_q  <= bst_act_d;
            bst_wr_q   <= bst_wr_d;
            bst_bank_q <= bst_bank_d;
            bst_row_q  <= bst_row_d;
            bst_col_q  <= bst_col_d;
            bst_idx_q  <= bst_idx_d;
            bst_len_q  <= bst_len_d;
            rd_vld_q   <= rd_vld_d;
            p1_vld_q   <= p1_vld_d;
            p1_dat_q   <= p1_dat_d;
            p2_vld_q   <= p2_vld_d;
            p2_dat_q   <= p2_dat_d;
            dq_oe_q    <= dq_oe_d;
            dq_q       <= dq_d;
        end
    end

    assign REF_COUNT = ref_q;

`ifdef SDRAM_RESP_CHECK_EN
    logic err_q, err_d, viol_s;

    // Protocol violations seen on this edge.
    always_comb begin
        viol_s = 1'b0;
        case (cmd_s)
            CMD_READ, CMD_WRITE: viol_s = !open_q[BA];
            CMD_ACTIVE:          viol_s = open_q[BA];
            CMD_AUTO_REFRESH:    viol_s = |open_q;
            CMD_LOAD_MODE:       viol_s = (|open_q) ||
                                          !cl_legal(ADDR[MODE_CL_MSB:MODE_CL_LSB]) ||
                                          !bl_legal(ADDR[MODE_BL_MSB:MODE_BL_LSB]);
            default:             viol_s = 1'b0;
        endcase
        err_d = err_q || viol_s;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
module tb_sdram_responder;

    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_BST = 4'b0110;
    localparam logic [3:0] C_NOP = 4'b0111;
    // An undriven bus floats high through the pull-ups.
    localparam logic [15:0] REL = 16'hFFFF;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        CKE;
    logic        CSn, RASn, CASn, WEn;
    logic [12:0] ADDR;
    logic [1:0]  BA;
    logic [1:0]  DQM;
    wire  [15:0] DQ;
    logic        ERR;
    logic [15:0] REF_COUNT;
    logic [15:0] tb_dq;
    logic        tb_dq_oe;

    int vectors = 0;
    int miscompares = 0;

    assign DQ = tb_dq_oe ? tb_dq : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pull
        pullup (DQ[i]);
    end

    always #5 HCLK = ~HCLK;

    sdram_responder dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .CKE(CKE),
        .CSn(CSn), .RASn(RASn), .CASn(CASn), .WEn(WEn),
        .ADDR(ADDR), .BA(BA), .DQ(DQ), .DQM(DQM),
        .ERR(ERR), .REF_COUNT(REF_COUNT)
    );

    // Present one command for one clock, returning at the following negedge.
    task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic oe, input logic [15:0] d, input logic [1:0] m);
        {CSn, RASn, CASn, WEn} = c;
        BA = ba; ADDR = a; tb_dq_oe = oe; tb_dq = d; DQM = m;
        @(negedge HCLK);
    endtask

    task automatic nop();
        drive(C_NOP, 2'd0, 13'd0, 1'b0, 16'h0000, 2'b00);
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; CKE = 1'b1;
        {CSn, RASn, CASn, WEn} = C_NOP; BA = 2'd0; ADDR = 13'd0;
        DQM = 2'b00; tb_dq_oe = 1'b0; tb_dq = 16'h0000;
        repeat (2) @(negedge HCLK);
        vectors++;
        if (REF_COUNT !== 16'd0) begin miscompares++; $display("FAIL reset_ref got %h want 0000", REF_COUNT); end
        vectors++;
        if (ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", ERR); end
        vectors++;
        if (DQ !== REL) begin miscompares++; $display("FAIL reset_dq got %h want %h", DQ, REL); end
        HRESETn = 1'b1;
        nop();
    endtask

    task automatic test_basic();
        drive(C_LMR, 2'd0, 13'h020, 1'b0, 16'h0000, 2'b00);
        drive(C_ACT, 2'd0, 13'd5, 1'b0, 16'h0000, 2'b00);
        drive(C_WR, 2'd0, 13'd3, 1'b1, 16'hA5A5, 2'b00);
        drive(C_RD, 2'd0, 13'd3, 1'b0, 16'h0000, 2'b00);
        nop(); nop();
        vectors++;
        if (DQ !== 16'hA5A5) begin miscompares++; $display("FAIL basic_read got %h want A5A5", DQ); end
        nop();
        vectors++;
        if (DQ !== REL) begin miscompares++; $display("FAIL basic_release got %h want %h", DQ, REL); end
        vectors++;
        if (ERR !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b want 0", ERR); end
    endtask

    task automatic test_burst_wrap();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'd3; exp_w[1] = 16'd4; exp_w[2] = 16'd1; exp_w[3] = 16'd2;
        drive(C_PRE, 2'd0, 13'h400, 1'b0, 16'h0000, 2'b00);
        drive(C_LMR, 2'd0, 13'h032, 1'b0, 16'h0000, 2'b00);
        drive(C_ACT, 2'd0, 13'd5, 1'b0, 16'h0000, 2'b00);
        drive(C_WR, 2'd0, 13'd6, 1'b1, 16'd1, 2'b00);
        for (int k = 2; k <= 4; k++) drive(C_NOP, 2'd0, 13'd0, 1'b1, 16'(k), 2'b00);
        drive(C_RD, 2'd0, 13'd4, 1'b0, 16'h0000, 2'b00);
        nop(); nop();
        for (int k = 0; k < 4; k++) begin
            nop();
            vectors++;
            if (DQ !== exp_w[k]) begin miscompares++; $display("FAIL wrap_word%0d got %h want %h", k, DQ, exp_w[k]); end
        end
        nop();
        vectors++;
        if (DQ !== REL) begin miscompares++; $display("FAIL wrap_release got %h want %h", DQ, REL); end
    endtask

    task automatic test_dqm();
        drive(C_PRE, 2'd0, 13'h400, 1'b0, 16'h0000, 2'b00);
        drive(C_LMR, 2'd0, 13'h020, 1'b0, 16'h0000, 2'b00);
        drive(C_ACT, 2'd1, 13'd2, 1'b0, 16'h0000, 2'b00);
        drive(C_WR, 2'd1, 13'd10, 1'b1, 16'h1234, 2'b00);
        drive(C_WR, 2'd1, 13'd10, 1'b1, 16'hFFFF, 2'b10);
        drive(C_RD, 2'd1, 13'd10, 1'b0, 16'h0000, 2'b00);
        nop(); nop();
        vectors++;
        if (DQ !== 16'h12FF) begin miscompares++; $display("FAIL dqm_merge got %h want 12FF", DQ); end
    endtask

    task automatic test_burst_stop();
        drive(C_PRE, 2'd0, 13'h400, 1'b0, 16'h0000, 2'b00);
        drive(C_LMR, 2'd0, 13'h023, 1'b0, 16'h0000, 2'b00);
        drive(C_ACT, 2'd2, 13'd1, 1'b0, 16'h0000, 2'b00);
        drive(C_WR, 2'd2, 13'd0, 1'b1, 16'h0100, 2'b00);
        for (int k = 1; k < 8; k++) drive(C_NOP, 2'd0, 13'd0, 1'b1, 16'h0100 + 16'(k), 2'b00);
        drive(C_RD, 2'd2, 13'd0, 1'b0, 16'h0000, 2'b00);
        nop(); nop();
        vectors++;
        if (DQ !== 16'h0100) begin miscompares++; $display("FAIL bst_word0 got %h want 0100", DQ); end
        drive(C_BST, 2'd0, 13'd0, 1'b0, 16'h0000, 2'b00);
        vectors++;
        if (DQ !== 16'h0101) begin miscompares++; $display("FAIL bst_word1 got %h want 0101", DQ); end
        nop();
        vectors++;
        if (DQ !== 16'h0102) begin miscompares++; $display("FAIL bst_word2 got %h want 0102", DQ); end
        for (int k = 0; k < 2; k++) begin
            nop();
            vectors++;
            if (DQ !== REL) begin miscompares++; $display("FAIL bst_release%0d got %h want %h", k, DQ, REL); end
        end
    endtask

    task automatic test_back_to_back();
        drive(C_PRE, 2'd0, 13'h400, 1'b0, 16'h0000, 2'b00);
        drive(C_LMR, 2'd0, 13'h020, 1'b0, 16'h0000, 2'b00);
        drive(C_ACT, 2'd1, 13'd2, 1'b0, 16'h0000, 2'b00);
        drive(C_RD, 2'd1, 13'd10, 1'b0, 16'h0000, 2'b00);
        drive(C_WR, 2'd1, 13'd11, 1'b1, 16'h5A5A, 2'b00);
        nop();
        vectors++;
        if (DQ !== REL) begin miscompares++; $display("FAIL wr_wins_release got %h want %h", DQ, REL); end
        drive(C_RD, 2'd1, 13'd11, 1'b0, 16'h0000, 2'b00);
        nop(); nop();
        vectors++;
        if (DQ !== 16'h5A5A) begin miscompares++; $display("FAIL wr_wins_data got %h want 5A5A", DQ); end
    endtask

    task automatic test_refresh();
        drive(C_PRE, 2'd0, 13'h400, 1'b0, 16'h0000, 2'b00);
        for (int k = 0; k < 3; k++) drive(C_REF, 2'd0, 13'd0, 1'b0, 16'h0000, 2'b00);
        vectors++;
        if (REF_COUNT !== 16'd3) begin miscompares++; $display("FAIL ref_count got %h want 0003", REF_COUNT); end
        HRESETn = 1'b0;
        #1;
        vectors++;
        if (REF_COUNT !== 16'd0) begin miscompares++; $display("FAIL ref_after_reset got %h want 0000", REF_COUNT); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        nop();
        // Reset mode is CL=2, BL=1; the earlier merged word must still be there.
        drive(C_ACT, 2'd1, 13'd2, 1'b0, 16'h0000, 2'b00);
        drive(C_RD, 2'd1, 13'd10, 1'b0, 16'h0000, 2'b00);
        nop(); nop();
        vectors++;
        if (DQ !== 16'h12FF) begin miscompares++; $display("FAIL mem_kept got %h want 12FF", DQ); end
    endtask

    task automatic test_cke();
        CKE = 1'b0;
        drive(C_WR, 2'd1, 13'd10, 1'b1, 16'h0000, 2'b00);
        CKE = 1'b1;
        drive(C_RD, 2'd1, 13'd10, 1'b0, 16'h0000, 2'b00);
        nop(); nop();
        vectors++;
        if (DQ !== 16'h12FF) begin miscompares++; $display("FAIL cke_ignore got %h want 12FF", DQ); end
    endtask

    task automatic test_check();
        logic exp_err;
`ifdef SDRAM_RESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        nop();
        drive(C_RD, 2'd3, 13'd0, 1'b0, 16'h0000, 2'b00);
        vectors++;
        if (ERR !== exp_err) begin miscompares++; $display("FAIL err_set got %b want %b", ERR, exp_err); end
        nop(); nop();
        vectors++;
        if (ERR !== exp_err) begin miscompares++; $display("FAIL err_hold got %b want %b", ERR, exp_err); end
        HRESETn = 1'b0;
        #1;
        vectors++;
        if (ERR !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", ERR); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        nop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_burst_wrap();
        test_dqm();
        test_burst_stop();
        test_back_to_back();
        test_refresh();
        test_cke();
        test_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 12: log2 of emulated 16-bit word depth.
REQ-002 SHALL have parameter ROW_BITS, default 13, and COL_BITS, default 9: logical SDRAM geometry.
REQ-003 SHALL have port HCLK, input, 1: single clock; all logic rises on its posedge; one clock only.
REQ-004 SHALL have port HRESETn, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port CKE, input, 1: clock enable; commands ignored while low.
REQ-006 SHALL have ports CSn, RASn, CASn and WEn, input, 1 each: command bits.
REQ-007 SHALL have port ADDR, input, 13: row, column or mode bits; ADDR[10] is the auto/all flag.
REQ-008 SHALL have port BA, input, 2: bank select.
REQ-009 SHALL have port DQ, inout, 16: data, high-Z unless driving read data.
REQ-010 SHALL have port DQM, input, 2: byte write mask (1 = masked), [1] upper byte.
REQ-011 SHALL have port ERR, output, 1: sticky protocol-violation flag.
REQ-012 SHALL have port REF_COUNT, output, 16: auto-refresh counter, wraps at 0xFFFF.

Function
REQ-013 SHALL decode {CSn,RASn,CASn,WEn} at each posedge with CKE=1: 1xxx/0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE, 0110 BURST_STOP.
REQ-014 SHALL keep per-bank open flag and row register; ACTIVE sets both from BA/ADDR, PRECHARGE clears BA's flag, or all four flags when ADDR[10]=1.
REQ-015 SHALL latch on LOAD_MODE: CL = ADDR[6:4] (2 or 3 legal), BL = ADDR[2:0] (0..3 -> 1,2,4,8); burst type sequential only.
REQ-016 SHALL form the word address as the low MEM_AW bits of {BA, open row, column}.
REQ-017 SHALL, on READ at edge T, drive DQ with word k of the burst during cycle T+CL+k, k = 0..BL-1, then release to high-Z.
REQ-018 SHALL, on WRITE at edge T, store DQ at edges T..T+BL-1, skipping bytes whose DQM bit is 1.
REQ-019 SHALL increment the burst column modulo BL within the BL-aligned block (wrap, e.g. col 6, BL=4 -> 6,7,4,5).
REQ-020 SHALL let a new READ/WRITE, BURST_STOP or PRECHARGE of the burst's bank truncate the active burst; read words already in the CL pipeline still appear.
REQ-021 SHALL, for READ followed by WRITE overlapping on DQ, release DQ on the WRITE edge (write wins).
REQ-022 SHALL increment REF_COUNT on AUTO_REFRESH.
REQ-023 SHALL ignore ADDR/BA/DQ and freeze burst counters while CKE=0.

Reset
REQ-024 SHALL on HRESETn=0 immediately: close all banks, CL=2, BL=1, abort bursts, release DQ, clear ERR and REF_COUNT.
REQ-025 SHALL keep memory contents across reset; reset mid-burst drops remaining words.

Configuration
REQ-026 SHALL, with SDRAM_RESP_CHECK_EN defined, set ERR on any of: READ/WRITE to closed bank; ACTIVE to open bank; AUTO_REFRESH or LOAD_MODE with any bank open; illegal CL or BL code.
REQ-027 SHALL, without SDRAM_RESP_CHECK_EN, tie ERR to 0 and omit the checker logic; illegal codes then keep the previous mode.

Structure
REQ-028 SHALL take command encodings, mode field positions and CL/BL decode constants from shared package sdram_pkg, also used by the controller.
REQ-029 SHALL keep storage in sub-module sdram_resp_mem: 2^MEM_AW x 16, one synchronous write port with byte enables, one synchronous read port.

Verification
REQ-030 SHALL pass: LOAD_MODE CL=2 BL=1, ACTIVE b0 r5, WRITE c3 0xA5A5, READ c3 -> DQ=0xA5A5 two cycles after READ, ERR=0.
REQ-031 SHALL pass: CL=3 BL=4, WRITE c6 data 1,2,3,4 -> READ c4 returns 3,4,1,2 starting three cycles after READ.
REQ-032 SHALL pass: WRITE 0x1234 then WRITE same address 0xFFFF with DQM=2'b10 -> read 0x12FF.
REQ-033 SHALL pass: BL=8 READ, BURST_STOP at word 3 -> words 0..2 plus CL pipeline words only, then DQ high-Z.
REQ-034 SHALL pass: READ to closed bank with SDRAM_RESP_CHECK_EN -> ERR=1 next cycle, held until HRESETn=0.
REQ-035 SHALL pass: 3 AUTO_REFRESH with all banks closed -> REF_COUNT=3; HRESETn pulse -> REF_COUNT=0, memory intact.
